// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states
// and the byte-lane merge used by sub-word stores.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Replace the addressed lane(s) of i_old with the low bits of i_lane.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] i_old,
        input logic [31:0] i_lane,
        input logic [1:0]  i_size,
        input logic [1:0]  i_off
    );
        logic [31:0] merged;
        merged = i_old;
        case (i_size)
            SIZE_B:  merged[{i_off, 3'b000} +: 8] = i_lane[7:0];
            SIZE_H:  merged[{i_off[1], 4'b0000} +: 16] = i_lane[15:0];
            default: merged = i_lane;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Little-endian lane select of a 32-bit word with sign/zero extension by size.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            SIZE_B:  o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_H:  o_data = {{16{i_signed & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-to-unified-memory bridge: byte/halfword/word loads and stores mapped onto
// word-wide memory cycles, with read-modify-write for sub-word stores.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int RAM_SIZE_BIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_merge;
    logic        r_ready;
    logic        r_done;
    logic        r_err;
    logic        r_mem_read;
    logic        r_mem_write;

    logic        w_bad;
    logic [31:0] w_load_data;
    logic [31:0] w_store_lane;

    // Priority order matters only for which check fires; any hit rejects.
    always_comb begin
        w_bad = 1'b0;
        if (req_size == 2'b11)
            w_bad = 1'b1;
        else if (req_size == SIZE_H && req_addr[0])
            w_bad = 1'b1;
        else if (req_size == SIZE_W && req_addr[1:0] != 2'b00)
            w_bad = 1'b1;
        else if ((req_addr >> (RAM_SIZE_BIT + 2)) != 32'd0)
            w_bad = 1'b1;
    end

    load_extend u_load_extend (
        .i_word   (mem_rdata),
        .i_size   (r_size),
        .i_off    (r_addr[1:0]),
        .i_signed (r_signed),
        .o_data   (w_load_data)
    );

    // Offset 0 and zero-extend: just isolates the low byte/halfword of the store data.
    load_extend u_store_lane (
        .i_word   (r_wdata),
        .i_size   (r_size),
        .i_off    (2'b00),
        .i_signed (1'b0),
        .o_data   (w_store_lane)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_size      <= SIZE_B;
            r_signed    <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_merge     <= 32'd0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_we     <= req_we;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_ready  <= 1'b0;
                        if (w_bad) begin
                            r_state <= ST_RESP;
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_rdata <= 32'd0;
                        end else if (!req_we) begin
                            r_state    <= ST_LOAD;
                            r_mem_read <= 1'b1;
                        end else if (req_size == SIZE_W) begin
                            r_state     <= ST_WRITE;
                            r_mem_write <= 1'b1;
                            r_merge     <= req_wdata;
                        end else begin
                            r_state    <= ST_RMW_RD;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    r_rdata <= w_load_data;
                    r_done  <= 1'b1;
                    r_state <= ST_RESP;
                end
                ST_WRITE: begin
                    r_rdata <= 32'd0;
                    r_done  <= 1'b1;
                    r_state <= ST_RESP;
                end
                ST_RMW_RD: begin
                    r_merge     <= lane_merge(mem_rdata, w_store_lane, r_size, r_addr[1:0]);
                    r_mem_write <= 1'b1;
                    r_state     <= ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    r_rdata <= 32'd0;
                    r_done  <= 1'b1;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_merge;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-array memory, an
// arithmetic reference model and a per-cycle compare process.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        ready, done, err, mem_read, mem_write;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem     [256] = '{default: 32'd0};
    logic [31:0] ref_mem [256] = '{default: 32'd0};

    int n_checks = 0;
    int n_errors = 0;

    mem_access_unit #(.RAM_SIZE_BIT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ready      (ready),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction tracking and model expectations.
    logic        s_acc, s_we, s_sg;
    logic [1:0]  s_sz;
    logic [31:0] s_addr, s_wd;
    logic        pend = 1'b0;
    int          lat, exp_lat, n_rd, n_wr, rd_at, wr_at, exp_rd, exp_wr;
    logic        exp_err;
    logic [31:0] exp_rdata, exp_new, t_addr;
    int          n_acc = 0;
    int          done_cnt = 0;
    int          last_lat;
    logic        last_err;
    logic [31:0] last_rdata;

    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] old, v, mask;
        int sh;
        old = ref_mem[a[9:2]];
        sh  = int'(a[1:0]) * 8;
        exp_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
                  (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd1024);
        exp_new = old;
        exp_rdata = 32'd0;
        if (exp_err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
            if (sz == 2'd0) begin
                v = (old >> sh) & 32'hFF;
                if (sg && v >= 32'd128) v = v - 32'd256;
            end else if (sz == 2'd1) begin
                v = (old >> sh) & 32'hFFFF;
                if (sg && v >= 32'd32768) v = v - 32'd65536;
            end else
                v = old;
            exp_rdata = v;
        end else if (sz == 2'd2) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
            exp_new = wd;
        end else begin
            exp_lat = 3; exp_rd = 1; exp_wr = 1;
            mask = (sz == 2'd0) ? (32'hFF << sh) : (32'hFFFF << sh);
            exp_new = (old & ~mask) | ((wd << sh) & mask);
        end
    endtask

    always @(posedge clk) begin
        s_acc  = req && ready && !reset;
        s_we   = req_we; s_sz = req_size; s_sg = req_signed;
        s_addr = req_addr; s_wd = req_wdata;
        #1;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (s_acc) begin
                model(s_we, s_sz, s_sg, s_addr, s_wd);
                t_addr = s_addr;
                pend = 1'b1; lat = 0; n_rd = 0; n_wr = 0; rd_at = 0; wr_at = 0;
                n_acc++;
            end
            if (pend) lat++;
            chk("ready", 32'(ready), 32'(!pend));
            chk("done", 32'(done), 32'(pend && lat == exp_lat));
            chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
            if (pend) begin
                chk("mem_addr", mem_addr, {t_addr[31:2], 2'b00});
                if (mem_read)  begin n_rd++; rd_at = lat; end
                if (mem_write) begin
                    n_wr++; wr_at = lat;
                    chk("mem_wdata", mem_wdata, exp_new);
                end
                if (lat >= exp_lat) begin
                    chk("err", 32'(err), 32'(exp_err));
                    chk("rdata", rdata, exp_rdata);
                    chk("read_pulses", n_rd, exp_rd);
                    chk("write_pulses", n_wr, exp_wr);
                    if (exp_rd == 1 && exp_wr == 1) chk("read_before_write", 32'(rd_at < wr_at), 32'd1);
                    chk("mem_word", mem[t_addr[9:2]], exp_new);
                    ref_mem[t_addr[9:2]] = exp_new;
                    last_lat = lat; last_err = err; last_rdata = rdata;
                    done_cnt++;
                    pend = 1'b0;
                end
            end else begin
                chk("idle_no_mem", 32'(mem_read | mem_write), 32'd0);
            end
        end
    end

    task automatic xfer(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
        int k, d0;
        k = 0;
        while (!ready && k < 20) begin @(negedge clk); k++; end
        req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        d0 = done_cnt;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 12) begin @(negedge clk); k++; end
        chk("xfer_completes", 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int a0;
        #12;
        chk_reset_vals("rst");
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        // word store then load
        xfer(1, 2'd2, 0, 32'h40, 32'h12345678);
        chk("sw_lat", last_lat, 2);
        xfer(0, 2'd2, 0, 32'h40, 32'h0);
        chk("lw_rdata", last_rdata, 32'h12345678);
        chk("lw_lat", last_lat, 2);
        chk("lw_err", 32'(last_err), 32'd0);

        // signed / unsigned sub-word loads
        xfer(1, 2'd2, 0, 32'h40, 32'h80FF7F01);
        xfer(0, 2'd0, 1, 32'h42, 32'h0);
        chk("lb_42", last_rdata, 32'hFFFFFFFF);
        xfer(0, 2'd0, 0, 32'h42, 32'h0);
        chk("lbu_42", last_rdata, 32'h000000FF);
        xfer(0, 2'd0, 1, 32'h43, 32'h0);
        chk("lb_43", last_rdata, 32'hFFFFFF80);
        xfer(0, 2'd1, 1, 32'h42, 32'h0);
        chk("lh_42", last_rdata, 32'hFFFF80FF);
        xfer(0, 2'd1, 0, 32'h40, 32'h0);
        chk("lhu_40", last_rdata, 32'h00007F01);

        // read-modify-write stores
        xfer(1, 2'd2, 0, 32'h40, 32'h11223344);
        xfer(1, 2'd0, 0, 32'h41, 32'h000000AB);
        chk("sb_lat", last_lat, 3);
        xfer(1, 2'd1, 0, 32'h42, 32'h0000BEEF);
        chk("sh_lat", last_lat, 3);
        chk("rmw_mem", mem[16], 32'hBEEFAB44);

        // rejected requests
        xfer(0, 2'd1, 0, 32'h41, 32'h0);
        chk("lh_mis_err", 32'(last_err), 32'd1);
        chk("lh_mis_lat", last_lat, 1);
        xfer(0, 2'd2, 0, 32'h42, 32'h0);
        chk("lw_mis_err", 32'(last_err), 32'd1);
        xfer(1, 2'd3, 0, 32'h40, 32'hDEADBEEF);
        chk("rsvd_err", 32'(last_err), 32'd1);
        xfer(0, 2'd2, 0, 32'h400, 32'h0);
        chk("oor_err", 32'(last_err), 32'd1);
        xfer(1, 2'd2, 0, 32'h3FC, 32'hCAFEF00D);
        chk("last_word_ok", 32'(last_err), 32'd0);
        chk("err_mem_kept", mem[16], 32'hBEEFAB44);

        // req held high across a sub-word store: accepts at edges 0 and 4 only
        while (!ready) @(negedge clk);
        req_we = 1; req_size = 2'd0; req_signed = 0; req_addr = 32'h41; req_wdata = 32'hCD;
        a0 = n_acc;
        req = 1'b1;
        repeat (6) @(negedge clk);
        req = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_accepts", n_acc - a0, 2);
        chk("busy_mem", mem[16], 32'hBEEFCD44);

        // reset while in RMW_RD
        while (!ready) @(negedge clk);
        req_we = 1; req_size = 2'd0; req_addr = 32'h41; req_wdata = 32'h55;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("rmw_rd_reading", 32'(mem_read), 32'd1);
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        chk("midrst_no_write", 32'(mem_write), 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_mem_kept", mem[16], 32'hBEEFCD44);
        xfer(0, 2'd2, 0, 32'h40, 32'h0);
        chk("post_rst_lw", last_rdata, 32'hBEEFCD44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
